trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller.sv | 146 ++++++++++++++
 tb/tb_trap_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Trap sequencer: accepts one illegal/ecall/irq/mret event, pulses its commit, flushes, redirects.
// Optional macro TRAP_CTRL_IRQ_EN enables irq_i gated by mstatus_mie_i.
module trap_controller #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        illegal_i,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic        irq_i,
   input  logic        mstatus_mie_i,
   input  logic [31:0] pc_idex_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   output logic        excep_en_o,
   output logic        sys_call_en_o,
   output logic        mret_en_o,
   output logic [5:0]  cause_o,
   output logic [31:0] epc_o,
   output logic        flush_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {StIdle, StCommit, StFlush, StRedirect} state_e;
   typedef enum logic [1:0] {KindIllegal, KindEcall, KindIrq, KindMret} kind_e;

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        irq_valid;
   logic        accept;
   logic        unused_inputs;

   logic        excep_en_d, sys_call_en_d, mret_en_d, flush_d, redirect_d, busy_d;
   logic [5:0]  cause_d;
   logic [31:0] epc_d, redirect_pc_d;

`ifdef TRAP_CTRL_IRQ_EN
   assign irq_valid     = irq_i & mstatus_mie_i;
   assign unused_inputs = ^{mtvec_i[1:0], mepc_i[0]};
`else
   assign irq_valid     = 1'b0;
   assign unused_inputs = ^{irq_i, mstatus_mie_i, mtvec_i[1:0], mepc_i[0]};
`endif

   assign accept = (state_q == StIdle) && !stall_i &&
                   (illegal_i || ecall_i || irq_valid || mret_i);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         kind_q  <= KindIllegal;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StCommit;
               if (illegal_i)      kind_d = KindIllegal;
               else if (ecall_i)   kind_d = KindEcall;
               else if (irq_valid) kind_d = KindIrq;
               else                kind_d = KindMret;
            end
         end
         StCommit: begin
            state_d = StFlush;
            cnt_d   = 4'(FLUSH_CYCLES - 1);
         end
         StFlush: begin
            if (cnt_q == 4'd0) state_d = StRedirect;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StRedirect: state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Outputs are derived from the next state so they register alongside it
   always_comb begin
      excep_en_d    = (state_d == StCommit) && (kind_d == KindIllegal || kind_d == KindIrq);
      sys_call_en_d = (state_d == StCommit) && (kind_d == KindEcall);
      mret_en_d     = (state_d == StCommit) && (kind_d == KindMret);
      flush_d       = (state_d == StCommit) || (state_d == StFlush);
      redirect_d    = (state_d == StRedirect);
      busy_d        = (state_d != StIdle);
      cause_d       = cause_o;
      epc_d         = epc_o;
      redirect_pc_d = 32'd0;
      // mret is not a trap, so it leaves the last trap cause in place
      if (accept) begin
         epc_d = pc_idex_i;
         unique case (kind_d)
            KindIllegal: cause_d = 6'h02;
            KindEcall:   cause_d = 6'h0B;
            KindIrq:     cause_d = 6'h2B;
            default:     cause_d = cause_o;
         endcase
      end
      if (redirect_d) begin
         if (kind_d == KindMret) redirect_pc_d = {mepc_i[31:1], 1'b0};
         else                    redirect_pc_d = {mtvec_i[31:2], 2'b00};
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         excep_en_o    <= 1'b0;
         sys_call_en_o <= 1'b0;
         mret_en_o     <= 1'b0;
         cause_o       <= 6'd0;
         epc_o         <= 32'd0;
         flush_o       <= 1'b0;
         redirect_o    <= 1'b0;
         redirect_pc_o <= 32'd0;
         busy_o        <= 1'b0;
      end else begin
         excep_en_o    <= excep_en_d;
         sys_call_en_o <= sys_call_en_d;
         mret_en_o     <= mret_en_d;
         cause_o       <= cause_d;
         epc_o         <= epc_d;
         flush_o       <= flush_d;
         redirect_o    <= redirect_d;
         redirect_pc_o <= redirect_pc_d;
         busy_o        <= busy_d;
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: vector table of single events plus stall, busy and reset
// sequences. Define TRAP_CTRL_IRQ_EN for both bench and RTL to exercise the irq path.
module tb_trap_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0, illegal_i = 1'b0, ecall_i = 1'b0, mret_i = 1'b0;
   logic        irq_i = 1'b0, mstatus_mie_i = 1'b0;
   logic [31:0] pc_idex_i = 32'd0, mtvec_i = 32'd0, mepc_i = 32'd0;
   logic        excep_en_o, sys_call_en_o, mret_en_o, flush_o, redirect_o, busy_o;
   logic [5:0]  cause_o;
   logic [31:0] epc_o, redirect_pc_o;

   int checks = 0;
   int failures = 0;

   trap_controller #(.FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .illegal_i(illegal_i), .ecall_i(ecall_i),
      .mret_i(mret_i), .irq_i(irq_i), .mstatus_mie_i(mstatus_mie_i), .pc_idex_i(pc_idex_i),
      .mtvec_i(mtvec_i), .mepc_i(mepc_i), .excep_en_o(excep_en_o),
      .sys_call_en_o(sys_call_en_o), .mret_en_o(mret_en_o), .cause_o(cause_o),
      .epc_o(epc_o), .flush_o(flush_o), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ill, ecl, mrt, irq, mie;
      logic [31:0] pc, mtvec, mepc;
      logic        act;        // event expected to be accepted
      logic [2:0]  pulse;      // {excep, sys_call, mret}
      logic        chk_cause;
      logic [5:0]  cause;
      logic [31:0] target;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic ill, ecl, mrt, irq, mie,
                               input logic [31:0] pc, mtvec, mepc, input logic act,
                               input logic [2:0] pulse, input logic chk_cause,
                               input logic [5:0] cause, input logic [31:0] target);
      vec_t v;
      v.ill = ill; v.ecl = ecl; v.mrt = mrt; v.irq = irq; v.mie = mie;
      v.pc = pc; v.mtvec = mtvec; v.mepc = mepc; v.act = act; v.pulse = pulse;
      v.chk_cause = chk_cause; v.cause = cause; v.target = target;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_reqs();
      illegal_i = 1'b0; ecall_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      @(negedge clk);
      illegal_i = v.ill; ecall_i = v.ecl; mret_i = v.mrt; irq_i = v.irq;
      mstatus_mie_i = v.mie; pc_idex_i = v.pc; mtvec_i = v.mtvec; mepc_i = v.mepc;
      if (!v.act) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("v%0d idle busy", idx), 32'(busy_o), 32'd0);
            check($sformatf("v%0d idle pulses", idx),
                  32'({excep_en_o, sys_call_en_o, mret_en_o}), 32'd0);
         end
         clear_reqs();
         return;
      end
      @(negedge clk);  // COMMIT
      check($sformatf("v%0d commit pulses", idx),
            32'({excep_en_o, sys_call_en_o, mret_en_o}), 32'(v.pulse));
      if (v.chk_cause) check($sformatf("v%0d cause", idx), 32'(cause_o), 32'(v.cause));
      check($sformatf("v%0d epc", idx), epc_o, v.pc);
      check($sformatf("v%0d commit flush/busy", idx), 32'({flush_o, busy_o, redirect_o}),
            32'b110);
      clear_reqs();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);  // FLUSH
         check($sformatf("v%0d flush%0d", idx, c),
               32'({flush_o, busy_o, redirect_o, excep_en_o, sys_call_en_o, mret_en_o}),
               32'b110000);
      end
      @(negedge clk);  // REDIRECT
      check($sformatf("v%0d redirect", idx), 32'({flush_o, busy_o, redirect_o}), 32'b011);
      check($sformatf("v%0d target", idx), redirect_pc_o, v.target);
      @(negedge clk);  // back in IDLE
      check($sformatf("v%0d done", idx), 32'({busy_o, redirect_o, flush_o}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      //          ill ecl mrt irq mie pc            mtvec         mepc          act pulse  cc cause  target
      vecs[0] = mk(0, 1, 0, 0, 0, 32'h100,      32'h2000,     32'h0,        1, 3'b010, 1, 6'h0B, 32'h2000);
      vecs[1] = mk(1, 1, 1, 0, 0, 32'h204,      32'h2000,     32'h888,      1, 3'b100, 1, 6'h02, 32'h2000);
      vecs[2] = mk(0, 0, 1, 0, 0, 32'h400,      32'h2000,     32'h345,      1, 3'b001, 0, 6'h00, 32'h344);
      vecs[3] = mk(0, 1, 0, 0, 0, 32'h80,       32'h2003,     32'h0,        1, 3'b010, 1, 6'h0B, 32'h2000);
      vecs[4] = mk(0, 0, 0, 1, 0, 32'h60,       32'h3000,     32'h0,        0, 3'b000, 0, 6'h00, 32'h0);
`ifdef TRAP_CTRL_IRQ_EN
      vecs[5] = mk(0, 0, 0, 1, 1, 32'h64,       32'h3000,     32'h0,        1, 3'b100, 1, 6'h2B, 32'h3000);
      vecs[7] = mk(0, 0, 1, 1, 1, 32'h70,       32'h3004,     32'h501,      1, 3'b100, 1, 6'h2B, 32'h3004);
`else
      vecs[5] = mk(0, 0, 0, 1, 1, 32'h64,       32'h3000,     32'h0,        0, 3'b000, 0, 6'h00, 32'h0);
      vecs[7] = mk(0, 0, 1, 1, 1, 32'h70,       32'h3004,     32'h501,      1, 3'b001, 0, 6'h00, 32'h500);
`endif
      vecs[6] = mk(0, 1, 1, 0, 0, 32'h10,       32'h1000,     32'h20,       1, 3'b010, 1, 6'h0B, 32'h1000);
      vecs[8] = mk(1, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hABCDEF01, 32'h0,        1, 3'b100, 1, 6'h02, 32'hABCDEF00);

      // Reset state
      #2;
      check("reset ctrl", 32'({excep_en_o, sys_call_en_o, mret_en_o, flush_o, redirect_o, busy_o}),
            32'd0);
      check("reset cause", 32'(cause_o), 32'd0);
      check("reset epc", epc_o, 32'd0);
      check("reset rpc", redirect_pc_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Stall blocks acceptance; busy requests ignored; stall does not stretch a sequence
      @(negedge clk);
      stall_i = 1'b1; ecall_i = 1'b1; pc_idex_i = 32'h500; mtvec_i = 32'h2000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall busy", 32'({busy_o, sys_call_en_o}), 32'd0);
      end
      stall_i = 1'b0;
      @(negedge clk);
      check("stall release commit", 32'({busy_o, sys_call_en_o}), 32'b11);
      check("stall release epc", epc_o, 32'h500);
      clear_reqs();
      illegal_i = 1'b1; stall_i = 1'b1; pc_idex_i = 32'h600;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("busy ignores req", 32'({excep_en_o, flush_o}), 32'b01);
         check("busy cause held", 32'(cause_o), 32'h0B);
      end
      @(negedge clk);
      check("stalled redirect", 32'({redirect_o, busy_o}), 32'b11);
      check("stalled target", redirect_pc_o, 32'h2000);
      clear_reqs(); stall_i = 1'b0;
      @(negedge clk);
      check("no queued event", 32'({busy_o, excep_en_o}), 32'd0);
      check("epc held", epc_o, 32'h500);

      // Reset during FLUSH abandons the sequence
      ecall_i = 1'b1; pc_idex_i = 32'h700;
      @(negedge clk);
      clear_reqs();
      @(negedge clk);
      check("pre-reset flush", 32'(flush_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async reset ctrl", 32'({flush_o, busy_o, redirect_o}), 32'd0);
      check("async reset epc", epc_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post-reset quiet", 32'({redirect_o, busy_o, flush_o}), 32'd0);
      end
      run_vec(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
